// File: rtl/mlp_pkg.sv
// Shared constants and types for the MLP inference datapath: image loader, core
// and the result/display stage.
package mlp_pkg;

  localparam int unsigned NUM_PIX = 784;
  localparam int unsigned NUM_L1  = 16;
  localparam int unsigned NUM_OUT = 10;
  localparam int unsigned ADDR_W  = 10;

  typedef enum logic [1:0] {
    RECV,
    START,
    WAIT_DONE
  } loader_state_t;

endpackage

// File: rtl/mlp_image_loader.sv
// Streams one frame of pixels into the input-image RAM, kicks the MLP core and
// blocks the next frame until the core signals completion.
module mlp_image_loader #(
  parameter int unsigned NUM_PIX   = mlp_pkg::NUM_PIX,
  parameter int unsigned ADDR_W    = mlp_pkg::ADDR_W,
  parameter int unsigned PIX_SHIFT = 0
) (
  input  logic              CK,
  input  logic              RB,
  input  logic [7:0]        PIX_DATA_I,
  input  logic              PIX_SOF_I,
  input  logic              PIX_VALID_I,
  output logic              PIX_READY_O,
  output logic [ADDR_W-1:0] RAM_IF_WADDR_O,
  output logic [7:0]        RAM_IF_WDATA_O,
  output logic              RAM_IF_WE_O,
  output logic              EN_O,
  input  logic              DONE_I,
  output logic              BUSY_O,
  output logic              ERR_O,
  input  logic              CLR_ERR_I,
  output logic [7:0]        FRAME_CNT_O
);

  import mlp_pkg::*;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_PIX - 1);

  loader_state_t     state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q;
  logic              en_q;
  logic              busy_q;
  logic              err_q;
  logic [7:0]        fcnt_q;

  logic accept;
  logic store;
  logic err_set;

  // Ready also drops while reset is held so every output reads 0 during reset.
  assign PIX_READY_O = (state_q == RECV) && !RB;

  always_comb begin
    accept  = PIX_VALID_I && PIX_READY_O;
    store   = accept && (PIX_SOF_I || (cnt_q != '0));
    // Orphan byte at frame start, or SOF arriving mid-frame.
    err_set = accept && (PIX_SOF_I ? (cnt_q != '0) : (cnt_q == '0));
    waddr_d = PIX_SOF_I ? '0 : cnt_q;
    wdata_d = PIX_DATA_I >> PIX_SHIFT;
  end

  always_ff @(posedge CK or posedge RB) begin
    if (RB) begin
      state_q <= RECV;
      cnt_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      we_q <= 1'b0;
      en_q <= 1'b0;

      if (err_set) begin
        err_q <= 1'b1;
      end else if (CLR_ERR_I) begin
        err_q <= 1'b0;
      end

      case (state_q)
        RECV: begin
          if (store) begin
            we_q    <= 1'b1;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            if (waddr_d == LastAddr) begin
              cnt_q   <= '0;
              state_q <= START;
              en_q    <= 1'b1;
              busy_q  <= 1'b1;
              fcnt_q  <= fcnt_q + 8'd1;
            end else begin
              cnt_q <= waddr_d + 1'b1;
            end
          end
        end
        START: begin
          state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (DONE_I) begin
            state_q <= RECV;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= RECV;
        end
      endcase
    end
  end

  assign RAM_IF_WADDR_O = waddr_q;
  assign RAM_IF_WDATA_O = wdata_q;
  assign RAM_IF_WE_O    = we_q;
  assign EN_O           = en_q;
  assign BUSY_O         = busy_q;
  assign ERR_O          = err_q;
  assign FRAME_CNT_O    = fcnt_q;

endmodule

// File: tb/tb_mlp_image_loader.sv
// Two loaders share one pixel stream: a full-size frame with no shift and an
// 8-pixel frame with a 4-bit shift, both checked every cycle against a frame model.
module tb_mlp_image_loader;

  localparam int NPA = 784;
  localparam int NPB = 8;
  localparam int SHA = 0;
  localparam int SHB = 4;

  logic       CK = 1'b0;
  logic       RB = 1'b0;
  logic [7:0] PIX_DATA_I = 8'h00;
  logic       PIX_SOF_I = 1'b0;
  logic       PIX_VALID_I = 1'b0;
  logic       DONE_I = 1'b0;
  logic       CLR_ERR_I = 1'b0;

  logic       rdy[2];
  logic       we[2];
  logic [9:0] waddr[2];
  logic [7:0] wdata[2];
  logic       en[2];
  logic       busy[2];
  logic       err[2];
  logic [7:0] fcnt[2];

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int tgt = 0;
  bit gap_en = 1'b0;

  logic [7:0] ram[2][1024];
  int we_cnt[2] = '{0, 0};
  int en_cnt[2] = '{0, 0};
  bit cap_first = 1'b0;
  int first_addr = -1;

  // Frame-level reference state, one slot per loader.
  int m_cnt[2] = '{0, 0};
  bit m_busy[2] = '{0, 0};
  bit m_en[2] = '{0, 0};
  bit m_we[2] = '{0, 0};
  int m_addr[2] = '{0, 0};
  int m_data[2] = '{0, 0};
  bit m_err[2] = '{0, 0};
  int m_frames[2] = '{0, 0};

  always #5 CK = ~CK;

  mlp_image_loader #(.NUM_PIX(NPA), .ADDR_W(10), .PIX_SHIFT(SHA)) dut_a (
    .CK(CK), .RB(RB), .PIX_DATA_I(PIX_DATA_I), .PIX_SOF_I(PIX_SOF_I),
    .PIX_VALID_I(PIX_VALID_I), .PIX_READY_O(rdy[0]), .RAM_IF_WADDR_O(waddr[0]),
    .RAM_IF_WDATA_O(wdata[0]), .RAM_IF_WE_O(we[0]), .EN_O(en[0]), .DONE_I(DONE_I),
    .BUSY_O(busy[0]), .ERR_O(err[0]), .CLR_ERR_I(CLR_ERR_I), .FRAME_CNT_O(fcnt[0])
  );

  mlp_image_loader #(.NUM_PIX(NPB), .ADDR_W(10), .PIX_SHIFT(SHB)) dut_b (
    .CK(CK), .RB(RB), .PIX_DATA_I(PIX_DATA_I), .PIX_SOF_I(PIX_SOF_I),
    .PIX_VALID_I(PIX_VALID_I), .PIX_READY_O(rdy[1]), .RAM_IF_WADDR_O(waddr[1]),
    .RAM_IF_WDATA_O(wdata[1]), .RAM_IF_WE_O(we[1]), .EN_O(en[1]), .DONE_I(DONE_I),
    .BUSY_O(busy[1]), .ERR_O(err[1]), .CLR_ERR_I(CLR_ERR_I), .FRAME_CNT_O(fcnt[1])
  );

  function automatic int npix(input int k);
    return (k == 0) ? NPA : NPB;
  endfunction

  function automatic int shf(input int k);
    return (k == 0) ? SHA : SHB;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: inputs are stable at the clock edge (stimulus moves 1ns later).
  initial begin
    int  a;
    bit  acc, set, w, e;
    forever begin
      @(posedge CK or posedge RB);
      for (int k = 0; k < 2; k++) begin
        if (RB) begin
          m_cnt[k] = 0; m_busy[k] = 0; m_en[k] = 0; m_we[k] = 0;
          m_addr[k] = 0; m_data[k] = 0; m_err[k] = 0; m_frames[k] = 0;
        end else begin
          acc = PIX_VALID_I && !m_busy[k];
          set = 0; w = 0; e = 0;
          if (m_busy[k]) begin
            if (DONE_I && !m_en[k]) m_busy[k] = 0;
          end else if (acc) begin
            if (!PIX_SOF_I && m_cnt[k] == 0) begin
              set = 1;
            end else begin
              a = PIX_SOF_I ? 0 : m_cnt[k];
              if (PIX_SOF_I && m_cnt[k] != 0) set = 1;
              w = 1;
              m_addr[k] = a;
              m_data[k] = int'(PIX_DATA_I) >> shf(k);
              if (a == npix(k) - 1) begin
                m_cnt[k] = 0;
                m_busy[k] = 1;
                e = 1;
                m_frames[k] = (m_frames[k] + 1) % 256;
              end else begin
                m_cnt[k] = a + 1;
              end
            end
          end
          m_err[k] = set || (m_err[k] && !CLR_ERR_I);
          m_we[k] = w;
          m_en[k] = e;
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus a write-side image RAM.
  initial begin
    forever begin
      @(negedge CK);
      for (int k = 0; k < 2; k++) begin
        if (we[k] === 1'b1) begin
          ram[k][waddr[k]] = wdata[k];
          we_cnt[k]++;
          if (k == 0 && cap_first) begin
            first_addr = int'(waddr[0]);
            cap_first = 1'b0;
          end
        end
        if (en[k] === 1'b1) en_cnt[k]++;
        if (chk_en) begin
          chk($sformatf("ready[%0d]", k), rdy[k], !m_busy[k] && !RB);
          chk($sformatf("we[%0d]", k), we[k], m_we[k]);
          if (m_we[k]) begin
            chk($sformatf("waddr[%0d]", k), waddr[k], m_addr[k]);
            chk($sformatf("wdata[%0d]", k), wdata[k], m_data[k]);
          end
          chk($sformatf("en[%0d]", k), en[k], m_en[k]);
          chk($sformatf("busy[%0d]", k), busy[k], m_busy[k]);
          chk($sformatf("err[%0d]", k), err[k], m_err[k]);
          chk($sformatf("fcnt[%0d]", k), fcnt[k], m_frames[k]);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CK);
    #1;
  endtask

  task automatic idle();
    PIX_VALID_I = 1'b0;
    PIX_DATA_I = 8'($urandom);
    PIX_SOF_I = 1'($urandom);
  endtask

  // Holds the byte until the selected loader takes it; the other one sees it too.
  task automatic send_byte(input logic [7:0] d, input logic sof);
    int n;
    bit ok;
    if (gap_en && $urandom_range(3) == 0) begin
      idle();
      step($urandom_range(1, 2));
    end
    PIX_VALID_I = 1'b1;
    PIX_DATA_I = d;
    PIX_SOF_I = sof;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 4000) begin
      ok = rdy[tgt];
      step(1);
      n++;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake_timeout: got no accept, expected accept within 4000 cycles");
    end
  endtask

  task automatic pulse_done();
    step(2);
    DONE_I = 1'b1;
    step(1);
    DONE_I = 1'b0;
  endtask

  task automatic pulse_reset();
    #2;
    RB = 1'b1;
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ready"}, rdy[0], 0);
    chk({nm, "_we"}, we[0], 0);
    chk({nm, "_en"}, en[0], 0);
    chk({nm, "_busy"}, busy[0], 0);
    chk({nm, "_err"}, err[0], 0);
    chk({nm, "_fcnt"}, fcnt[0], 0);
    chk({nm, "_waddr"}, waddr[0], 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected finish within 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] img[NPA];
    int w0, e0, nbad;

    #1 RB = 1'b1;
    chk_en = 1'b1;
    step(3);
    chk_all_zero("in_reset");
    RB = 1'b0;
    step(1);
    chk("reset_ready", rdy[0], 1);
    chk("reset_fcnt", fcnt[0], 0);

    // Clean frame, value = address.
    w0 = we_cnt[0];
    for (int i = 0; i < NPA; i++) send_byte(8'(i), i == 0);
    idle();
    step(3);
    chk("clean_we_count", we_cnt[0] - w0, NPA);
    chk("clean_en_count", en_cnt[0], 1);
    chk("clean_fcnt", fcnt[0], 1);
    chk("clean_ram783", ram[0][783], 8'h0F);
    chk("clean_ram0", ram[0][0], 8'h00);
    chk("clean_err", err[0], 0);
    chk("clean_busy", busy[0], 1);

    // Second frame offered while the core is still busy.
    for (int i = 0; i < NPA; i++) img[i] = 8'($urandom);
    w0 = we_cnt[0];
    PIX_VALID_I = 1'b1;
    PIX_SOF_I = 1'b1;
    PIX_DATA_I = img[0];
    for (int i = 0; i < 10; i++) begin
      chk("bp_ready_low", rdy[0], 0);
      step(1);
    end
    chk("bp_no_we", we_cnt[0] - w0, 0);
    DONE_I = 1'b1;
    chk("bp_ready_at_done", rdy[0], 0);
    step(1);
    DONE_I = 1'b0;
    chk("bp_ready_rise", rdy[0], 1);
    for (int i = 0; i < NPA; i++) send_byte(img[i], i == 0);
    idle();
    step(3);
    nbad = 0;
    for (int i = 0; i < NPA; i++) if (ram[0][i] !== img[i]) nbad++;
    chk("frame2_intact", nbad, 0);
    chk("frame2_fcnt", fcnt[0], 2);
    pulse_done();

    // SOF re-asserted at pixel 300 restarts the frame.
    gap_en = 1'b1;
    e0 = en_cnt[0];
    for (int i = 0; i < 300; i++) send_byte(8'($urandom), i == 0);
    send_byte(8'hAA, 1'b1);
    for (int i = 0; i < NPA - 2; i++) send_byte(8'($urandom), 1'b0);
    idle();
    step(3);
    chk("restart_no_early_en", en_cnt[0] - e0, 0);
    chk("restart_err", err[0], 1);
    send_byte(8'($urandom), 1'b0);
    idle();
    step(3);
    chk("restart_en", en_cnt[0] - e0, 1);
    chk("restart_ram0", ram[0][0], 8'hAA);
    chk("restart_fcnt", fcnt[0], 3);
    pulse_done();

    // Orphan byte, clear, and set-beats-clear.
    gap_en = 1'b0;
    CLR_ERR_I = 1'b1;
    step(1);
    CLR_ERR_I = 1'b0;
    chk("clr_err", err[0], 0);
    w0 = we_cnt[0];
    send_byte(8'($urandom), 1'b0);
    idle();
    chk("orphan_err", err[0], 1);
    step(2);
    chk("orphan_no_we", we_cnt[0] - w0, 0);
    CLR_ERR_I = 1'b1;
    step(1);
    CLR_ERR_I = 1'b0;
    chk("orphan_clr", err[0], 0);
    CLR_ERR_I = 1'b1;
    send_byte(8'($urandom), 1'b0);
    CLR_ERR_I = 1'b0;
    idle();
    chk("set_beats_clr", err[0], 1);

    // Reset mid-frame, then mid-inference.
    gap_en = 1'b1;
    e0 = en_cnt[0];
    for (int i = 0; i < 500; i++) send_byte(8'($urandom), i == 0);
    pulse_reset();
    chk_all_zero("rst_midframe");
    idle();
    step(2);
    RB = 1'b0;
    step(3);
    chk("rst_midframe_no_en", en_cnt[0] - e0, 0);
    for (int i = 0; i < NPA; i++) send_byte(8'($urandom), i == 0);
    idle();
    step(4);
    e0 = en_cnt[0];
    pulse_reset();
    chk_all_zero("rst_midwait");
    step(2);
    RB = 1'b0;
    step(2);
    chk("rst_midwait_no_en", en_cnt[0] - e0, 0);
    cap_first = 1'b1;
    for (int i = 0; i < NPA; i++) send_byte(8'($urandom), i == 0);
    idle();
    step(3);
    chk("post_rst_first_addr", first_addr, 0);
    chk("post_rst_fcnt", fcnt[0], 1);
    pulse_done();

    // Shift and frame-counter wrap on the small loader.
    pulse_reset();
    step(2);
    RB = 1'b0;
    step(1);
    gap_en = 1'b0;
    tgt = 1;
    e0 = en_cnt[1];
    for (int f = 0; f < 256; f++) begin
      for (int i = 0; i < NPB; i++)
        send_byte((f == 0 && i == 0) ? 8'hF0 : 8'($urandom), i == 0);
      idle();
      step(2);
      if (f == 0) chk("shift_f0_to_0f", ram[1][0], 8'h0F);
      if (f == 254) chk("fcnt_255", fcnt[1], 255);
      pulse_done();
    end
    chk("fcnt_wrap", fcnt[1], 0);
    chk("wrap_en_count", en_cnt[1] - e0, 256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
